rf_write_arbiter: RTL and testbench

Shares the register file's single write port between several writeback sources: ALU result, memory load data, and the bench/boot loader that preloads the 8 registers. Each source sees a req/gnt handshake. The arbiter drives one registered write (enable/address/data) into the register file per cycle. It also reports a busy flag and a saturating contention counter for the top level's debug and Done logic.

---
 rtl/rf_write_arbiter.sv | 119 +++++++++++
 tb/tb_rf_write_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - single write-port arbiter for the register file.
// Define RF_ARB_RR_EN for round-robin selection; default build is fixed priority.
module rf_write_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 3,
  parameter int DW   = 8,
  parameter int CW   = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [NREQ-1:0]    Req,
  input  logic [NREQ*AW-1:0] ReqAddr,
  input  logic [NREQ*DW-1:0] ReqData,
  output logic [NREQ-1:0]    Gnt,
  output logic               WrEn,
  output logic [AW-1:0]      WrAddr,
  output logic [DW-1:0]      WrData,
  output logic               Busy,
  output logic [CW-1:0]      StallCnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic [CW-1:0] stall_q, stall_d;
  logic [PW-1:0] win_idx;
  logic          win_any;
  logic          multi_req;

`ifdef RF_ARB_RR_EN
  logic [PW-1:0] ptr_q, ptr_d;

  // Search starts at the pointer and wraps once around all requesters.
  always_comb begin
    int idx;
    win_idx = '0;
    win_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_any && Req[idx]) begin
        win_any = 1'b1;
        win_idx = PW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (win_any && !Reset) begin
      ptr_d = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + PW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  always_comb begin
    win_idx = '0;
    win_any = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (Req[i]) begin
        win_any = 1'b1;
        win_idx = PW'(i);
      end
    end
  end
`endif

  always_comb begin
    int cnt;
    cnt = 0;
    for (int i = 0; i < NREQ; i++) cnt = cnt + int'(Req[i]);
    multi_req = (cnt > 1);
  end

  always_comb begin
    Gnt = '0;
    if (win_any && !Reset) Gnt[win_idx] = 1'b1;
  end

  always_comb begin
    wr_en_d   = win_any;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    stall_d   = stall_q;
    if (win_any) begin
      wr_addr_d = ReqAddr[int'(win_idx)*AW +: AW];
      wr_data_d = ReqData[int'(win_idx)*DW +: DW];
    end
    if (multi_req && stall_q != {CW{1'b1}}) stall_d = stall_q + CW'(1);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      stall_q   <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      stall_q   <= stall_d;
    end
  end

  // Masking with Reset cancels a write already registered when reset arrives.
  assign WrEn     = wr_en_q & ~Reset;
  assign WrAddr   = wr_addr_q;
  assign WrData   = wr_data_q;
  assign StallCnt = stall_q;
  assign Busy     = (|Req) | WrEn;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - directed self-checking bench for rf_write_arbiter.
module tb_rf_write_arbiter;

  logic        Clk;
  logic        Reset;
  logic [2:0]  Req, Req2;
  logic [8:0]  ReqAddr;
  logic [23:0] ReqData;
  logic [2:0]  Gnt, Gnt2;
  logic        WrEn, WrEn2, Busy, Busy2;
  logic [2:0]  WrAddr, WrAddr2;
  logic [7:0]  WrData, WrData2;
  logic [7:0]  StallCnt;
  logic [1:0]  StallCnt2;

  int n_cmp = 0;
  int n_err = 0;

  rf_write_arbiter #(.NREQ(3), .AW(3), .DW(8), .CW(8)) u_dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .ReqAddr(ReqAddr), .ReqData(ReqData),
    .Gnt(Gnt), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .Busy(Busy),
    .StallCnt(StallCnt)
  );

  rf_write_arbiter #(.NREQ(3), .AW(3), .DW(8), .CW(2)) u_sat (
    .Clk(Clk), .Reset(Reset), .Req(Req2), .ReqAddr(ReqAddr), .ReqData(ReqData),
    .Gnt(Gnt2), .WrEn(WrEn2), .WrAddr(WrAddr2), .WrData(WrData2), .Busy(Busy2),
    .StallCnt(StallCnt2)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_slot(input int i, input logic [2:0] a, input logic [7:0] d);
    ReqAddr[i*3 +: 3] = a;
    ReqData[i*8 +: 8] = d;
  endtask

  initial begin
    Reset = 1'b1;
    Req   = 3'b111;
    Req2  = 3'b000;
    ReqAddr = '0;
    ReqData = '0;
    set_slot(0, 3'd1, 8'h11);
    set_slot(1, 3'd2, 8'h22);
    set_slot(2, 3'd3, 8'h33);

    // Reset held for two cycles with all requests up.
    cyc(); #4;
    check("rst1_gnt", 32'(Gnt), 32'h0);
    check("rst1_wren", 32'(WrEn), 32'h0);
    check("rst1_stall", 32'(StallCnt), 32'h0);
    cyc(); #4;
    check("rst2_gnt", 32'(Gnt), 32'h0);
    check("rst2_wraddr", 32'(WrAddr), 32'h0);
    check("rst2_wrdata", 32'(WrData), 32'h0);

    // Contention: each requester drops after its grant.
    cyc(); Reset = 1'b0; #4;
    check("c0_gnt", 32'(Gnt), 32'b001);
    check("c0_wren", 32'(WrEn), 32'h0);
    cyc(); Req = 3'b110; #4;
    check("c1_gnt", 32'(Gnt), 32'b010);
    check("c1_wren", 32'(WrEn), 32'h1);
    check("c1_wraddr", 32'(WrAddr), 32'd1);
    check("c1_wrdata", 32'(WrData), 32'h11);
    check("c1_stall", 32'(StallCnt), 32'd1);
    cyc(); Req = 3'b100; #4;
    check("c2_gnt", 32'(Gnt), 32'b100);
    check("c2_wraddr", 32'(WrAddr), 32'd2);
    check("c2_wrdata", 32'(WrData), 32'h22);
    check("c2_stall", 32'(StallCnt), 32'd2);
    cyc(); Req = 3'b000; #4;
    check("c3_gnt", 32'(Gnt), 32'h0);
    check("c3_wren", 32'(WrEn), 32'h1);
    check("c3_wraddr", 32'(WrAddr), 32'd3);
    check("c3_wrdata", 32'(WrData), 32'h33);
    check("c3_busy", 32'(Busy), 32'h1);
    check("c3_stall", 32'(StallCnt), 32'd2);
    cyc(); #4;
    check("c4_wren", 32'(WrEn), 32'h0);
    check("c4_busy", 32'(Busy), 32'h0);
    check("c4_wraddr_hold", 32'(WrAddr), 32'd3);

    // Single write from the load port.
    cyc(); Req = 3'b010; set_slot(1, 3'd5, 8'hA7); #4;
    check("s0_gnt", 32'(Gnt), 32'b010);
    cyc(); Req = 3'b000; #4;
    check("s1_wren", 32'(WrEn), 32'h1);
    check("s1_wraddr", 32'(WrAddr), 32'd5);
    check("s1_wrdata", 32'(WrData), 32'hA7);
    cyc(); #4;
    check("s2_wren", 32'(WrEn), 32'h0);
    check("s2_wrdata_hold", 32'(WrData), 32'hA7);

    // Selection policy with all requests held, starting from reset.
    cyc(); Reset = 1'b1;
    cyc(); Reset = 1'b0; Req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #4;
`ifdef RF_ARB_RR_EN
      check($sformatf("rr_gnt%0d", k), 32'(Gnt), 32'(3'b001 << (k % 3)));
`else
      check($sformatf("fp_gnt%0d", k), 32'(Gnt), 32'b001);
`endif
      cyc();
    end
    Req = 3'b000; #4;
    check("pol_stall", 32'(StallCnt), 32'd6);

    // Reset arriving while a write is in flight cancels it.
    cyc(); Reset = 1'b1;
    cyc(); Reset = 1'b0; Req = 3'b001; set_slot(0, 3'd6, 8'h5A); #4;
    check("mf0_gnt", 32'(Gnt), 32'b001);
    cyc(); Reset = 1'b1; Req = 3'b000; #4;
    check("mf1_wren", 32'(WrEn), 32'h0);
    check("mf1_gnt", 32'(Gnt), 32'h0);
    cyc(); Reset = 1'b0; #4;
    check("mf2_wren", 32'(WrEn), 32'h0);
    check("mf2_wraddr", 32'(WrAddr), 32'h0);
    check("mf2_busy", 32'(Busy), 32'h0);

    // Two-bit stall counter saturates at 3.
    cyc(); Req2 = 3'b011;
    for (int k = 1; k <= 10; k++) begin
      cyc(); #4;
      check($sformatf("sat_stall%0d", k), 32'(StallCnt2), (k < 3) ? 32'(k) : 32'd3);
    end
    Req2 = 3'b000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
